scroll_addr_gen: RTL and testbench

//   Pixel-address generator between the VGA timing stage and the 320x240 image ROM.

---
 rtl/scroll_addr_gen_if.sv | 27 ++
 rtl/scroll_addr_gen.sv | 145 ++++++++++++++
 tb/tb_scroll_addr_gen.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/scroll_addr_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : scroll_addr_gen_if
// Description : VGA-side bus between the timing stage and the scroll address
//               generator.
//               master : VGA timing side. Drives h_cnt, v_cnt and valid;
//                        receives pixel_addr.
//               slave  : address generator side.
//               Signals:
//                 h_cnt      [9:0]        horizontal count, 0..799
//                 v_cnt      [9:0]        vertical count, 0..524
//                 valid                   high inside the 640x480 visible area
//                 pixel_addr [ADDR_W-1:0] registered ROM address
// Revision    : 1.0 - initial release
// ============================================================================
interface scroll_addr_gen_if #(
  parameter int ADDR_W = 17
);
  logic [9:0]        h_cnt;
  logic [9:0]        v_cnt;
  logic              valid;
  logic [ADDR_W-1:0] pixel_addr;

  modport master (output h_cnt, output v_cnt, output valid, input pixel_addr);
  modport slave  (input h_cnt, input v_cnt, input valid, output pixel_addr);
endinterface
`default_nettype wire

// File: rtl/scroll_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : scroll_addr_gen
// Description : Maps 640x480 VGA counts to a 2x-downscaled 320x240 image ROM
//               address with a vertical scroll offset. A run/pause FSM, toggled
//               by btn_pulse, latches step ticks into a pending flag; the
//               offset is stepped only at frame start so that frames never tear.
// Ports       : clk        pixel clock
//               rst_n      asynchronous active-low reset
//               vga        scroll_addr_gen_if.slave (h_cnt, v_cnt, valid in;
//                          pixel_addr out, 1-cycle latency)
//               btn_pulse  one-cycle run/pause toggle
//               step_tick  one-cycle scroll-rate tick
//               dir_pulse  one-cycle direction toggle (SCROLL_REVERSE_EN only)
//               running    high in RUN
//               offset     current scroll offset, 0..IMG_H-1
// Config      : SCROLL_REVERSE_EN - adds dir_pulse and reverse scrolling.
// Revision    : 1.0 - initial release
// ============================================================================
module scroll_addr_gen #(
  parameter int IMG_W  = 320,
  parameter int IMG_H  = 240,
  parameter int STEP   = 1,
  parameter int ADDR_W = 17
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  scroll_addr_gen_if.slave vga,
  input  wire logic        btn_pulse,
  input  wire logic        step_tick,
`ifdef SCROLL_REVERSE_EN
  input  wire logic        dir_pulse,
`endif
  output logic             running,
  output logic [7:0]       offset
);

  typedef enum logic [0:0] {
    PAUSE = 1'b0,
    RUN   = 1'b1
  } state_t;

  localparam logic [8:0]        H9   = 9'(IMG_H);
  localparam logic [8:0]        S9   = 9'(STEP);
  localparam logic [9:0]        H10  = 10'(IMG_H);
  localparam logic [ADDR_W-1:0] W_A  = ADDR_W'(IMG_W);

  state_t state, state_nxt;
  logic   pending, pending_nxt;
  logic   frame_start;
  logic   apply_step;

  logic [8:0] off9;
  logic [8:0] fwd_sum;
  logic [8:0] fwd_val;
  logic [8:0] step_val;

  logic [9:0]        v_half;
  logic [9:0]        row_sum;
  logic [9:0]        row;
  logic [9:0]        col;
  logic [ADDR_W-1:0] addr_calc;

  assign frame_start = (vga.h_cnt == 10'd0) && (vga.v_cnt == 10'd0);
  assign apply_step  = frame_start && pending;

  // ---------------- run/pause FSM ----------------
  always_comb begin
    state_nxt = state;
    if (btn_pulse) begin
      state_nxt = (state == RUN) ? PAUSE : RUN;
    end
  end

  // A tick is judged against the current state, so a tick arriving together
  // with the toggling button follows the pre-toggle state. A tick landing on
  // the frame-start cycle re-arms pending for the following frame.
  always_comb begin
    pending_nxt = (pending && !frame_start) || (step_tick && (state == RUN));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= PAUSE;
      pending <= 1'b0;
    end else begin
      state   <= state_nxt;
      pending <= pending_nxt;
    end
  end

  assign running = (state == RUN);

  // ---------------- offset stepping ----------------
  assign off9    = {1'b0, offset};
  assign fwd_sum = off9 + S9;
  assign fwd_val = (fwd_sum >= H9) ? (fwd_sum - H9) : fwd_sum;

`ifdef SCROLL_REVERSE_EN
  logic       dir;
  logic [8:0] rev_val;

  assign rev_val  = (off9 < S9) ? (off9 + H9 - S9) : (off9 - S9);
  // dir is sampled before its own update, so a dir_pulse on the frame-start
  // cycle only affects later steps.
  assign step_val = dir ? rev_val : fwd_val;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir <= 1'b0;
    end else if (dir_pulse) begin
      dir <= ~dir;
    end
  end
`else
  assign step_val = fwd_val;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      offset <= 8'd0;
    end else if (apply_step) begin
      offset <= 8'(step_val);
    end
  end

  // ---------------- address path ----------------
  // Both (v_cnt>>1) and offset are below IMG_H in the visible area, so one
  // conditional subtract is enough to wrap the row.
  assign v_half    = vga.v_cnt >> 1;
  assign row_sum   = v_half + {2'b00, offset};
  assign row       = (row_sum >= H10) ? (row_sum - H10) : row_sum;
  assign col       = vga.h_cnt >> 1;
  assign addr_calc = ADDR_W'(row) * W_A + ADDR_W'(col);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga.pixel_addr <= '0;
    end else begin
      vga.pixel_addr <= vga.valid ? addr_calc : '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_scroll_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_scroll_addr_gen
// Description : Self-checking bench for scroll_addr_gen. Stimulus pushes the
//               expected (pixel_addr, offset, running) into a scoreboard queue;
//               a monitor pops and compares one entry per clock.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scroll_addr_gen;

  localparam int IMG_W  = 320;
  localparam int IMG_H  = 240;
  localparam int ADDR_W = 17;
`ifdef SCROLL_REVERSE_EN
  localparam bit REV_EN = 1'b1;
`else
  localparam bit REV_EN = 1'b0;
`endif

  typedef struct {
    logic [ADDR_W-1:0] addr;
    int                off;
    bit                run;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_pulse = 1'b0;
  logic       step_tick = 1'b0;
`ifdef SCROLL_REVERSE_EN
  logic       dir_pulse = 1'b0;
`endif
  logic       running;
  logic [7:0] offset;

  scroll_addr_gen_if #(.ADDR_W(ADDR_W)) vga ();

  scroll_addr_gen #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .STEP  (1),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .vga      (vga),
    .btn_pulse(btn_pulse),
    .step_tick(step_tick),
`ifdef SCROLL_REVERSE_EN
    .dir_pulse(dir_pulse),
`endif
    .running  (running),
    .offset   (offset)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  exp_t sb[$];

  // reference model state
  int m_off  = 0;
  bit m_pend = 1'b0;
  bit m_run  = 1'b0;
  bit m_dir  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Applies one cycle of inputs and records the expected post-edge outputs.
  task automatic drive(input int h, input int v, input bit vl, input bit b,
                       input bit t, input bit d);
    exp_t e;
    bit   fs;
    int   row;
    @(negedge clk);
    vga.h_cnt = 10'(h);
    vga.v_cnt = 10'(v);
    vga.valid = vl;
    btn_pulse = b;
    step_tick = t;
`ifdef SCROLL_REVERSE_EN
    dir_pulse = d;
`endif
    row    = ((v / 2) + m_off) % IMG_H;
    e.addr = vl ? ADDR_W'(row * IMG_W + h / 2) : '0;
    fs     = (h == 0) && (v == 0);
    if (fs && m_pend)
      m_off = m_dir ? (m_off + IMG_H - 1) % IMG_H : (m_off + 1) % IMG_H;
    m_pend = (m_pend && !fs) || (t && m_run);
    if (b) m_run = !m_run;
    if (d && REV_EN) m_dir = !m_dir;
    e.off = m_off;
    e.run = m_run;
    sb.push_back(e);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en && sb.size() > 0) begin
        e = sb.pop_front();
        chk("sb_addr",    32'(vga.pixel_addr), 32'(e.addr));
        chk("sb_offset",  32'(offset),         32'(e.off));
        chk("sb_running", 32'(running),        32'(e.run));
      end
    end
  end

  initial begin : stim
    int h, v;
    bit vl, b, t, d;
    vga.h_cnt = 10'd0;
    vga.v_cnt = 10'd0;
    vga.valid = 1'b0;
    #1;
    chk("reset_addr",    32'(vga.pixel_addr), 32'd0);
    chk("reset_offset",  32'(offset),         32'd0);
    chk("reset_running", 32'(running),        32'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // PAUSE: five ticks over three frames are ignored
    drive(100, 50, 1, 0, 1, 0);
    drive(0, 0, 1, 0, 0, 0);
    drive(20, 10, 1, 0, 1, 0);
    drive(30, 10, 1, 0, 1, 0);
    drive(0, 0, 1, 0, 0, 0);
    drive(5, 5, 1, 0, 1, 0);
    drive(6, 5, 1, 0, 1, 0);
    drive(0, 0, 1, 0, 0, 0);
    drive(2, 2, 1, 0, 0, 0);
    settle();
    chk("pause_addr_2_2", 32'(vga.pixel_addr), 32'd321);
    chk("pause_offset",   32'(offset),         32'd0);

    // RUN: three ticks in one frame give a single step at frame start
    drive(1, 1, 1, 1, 0, 0);
    drive(10, 4, 1, 0, 1, 0);
    drive(200, 100, 1, 0, 1, 0);
    drive(600, 400, 1, 0, 1, 0);
    settle();
    chk("run_offset_before_fs", 32'(offset),  32'd0);
    chk("run_running",          32'(running), 32'd1);
    drive(0, 0, 1, 0, 0, 0);
    settle();
    chk("run_offset_after_fs", 32'(offset), 32'd1);
    drive(0, 0, 1, 0, 0, 0);
    settle();
    chk("run_addr_0_0", 32'(vga.pixel_addr), 32'd320);

    // Wrap at IMG_H
    for (int i = 0; i < IMG_H && m_off != IMG_H - 1; i++) begin
      drive(3, 3, 1, 0, 1, 0);
      drive(0, 0, 1, 0, 0, 0);
    end
    settle();
    chk("wrap_offset_239", 32'(offset), 32'd239);
    drive(0, 2, 1, 0, 0, 0);
    settle();
    chk("wrap_addr_row0", 32'(vga.pixel_addr), 32'd0);
    drive(639, 479, 1, 0, 0, 0);
    settle();
    chk("wrap_addr_last", 32'(vga.pixel_addr), 32'(238 * 320 + 319));
    drive(3, 3, 1, 0, 1, 0);
    drive(0, 0, 1, 0, 0, 0);
    settle();
    chk("wrap_offset_0", 32'(offset), 32'd0);
    drive(639, 479, 1, 0, 0, 0);
    settle();
    chk("last_pixel_addr", 32'(vga.pixel_addr), 32'd76799);
    drive(700, 500, 0, 0, 0, 0);
    settle();
    chk("blank_addr", 32'(vga.pixel_addr), 32'd0);

    // Button and tick together while paused: tick judged against PAUSE
    drive(3, 3, 1, 1, 0, 0);
    drive(3, 3, 1, 1, 1, 0);
    drive(0, 0, 1, 0, 0, 0);
    settle();
    chk("simul_running", 32'(running), 32'd1);
    chk("simul_offset",  32'(offset),  32'd0);

`ifdef SCROLL_REVERSE_EN
    drive(3, 3, 1, 0, 0, 1);
    drive(3, 3, 1, 0, 1, 0);
    drive(0, 0, 1, 0, 0, 0);
    settle();
    chk("reverse_offset", 32'(offset), 32'd239);
`else
    drive(3, 3, 1, 0, 1, 0);
    drive(0, 0, 1, 0, 0, 0);
    settle();
    chk("forward_offset", 32'(offset), 32'd1);
`endif

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      vl = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) begin
        h  = 0;
        v  = 0;
        vl = 1'b1;
      end else if (vl) begin
        h = $urandom_range(0, 639);
        v = $urandom_range(0, 479);
      end else begin
        h = $urandom_range(0, 799);
        v = $urandom_range(480, 524);
      end
      b = ($urandom_range(0, 39) == 0);
      t = ($urandom_range(0, 3) == 0);
      d = ($urandom_range(0, 29) == 0);
      drive(h, v, vl, b, t, d);
    end

    // Make sure the offset is mid-range before the asynchronous reset test
    if (!m_run) drive(3, 3, 1, 1, 0, 0);
    drive(3, 3, 1, 0, 1, 0);
    drive(0, 0, 1, 0, 0, 0);
    drive(100, 100, 1, 0, 0, 0);
    settle();
    mon_en = 1'b0;
    chk("sb_drained", 32'(sb.size()), 32'd0);

    // Asynchronous reset mid-frame, away from any clock edge
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_reset_addr",    32'(vga.pixel_addr), 32'd0);
    chk("async_reset_offset",  32'(offset),         32'd0);
    chk("async_reset_running", 32'(running),        32'd0);
    @(posedge clk);
    #1;
    chk("held_reset_addr", 32'(vga.pixel_addr), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
